// File: rtl/adc_channel_monitor_if.sv
// Sample, limit-write and average-output bundle shared by the ADC channel monitor and its
// sample source / register host.
interface adc_channel_monitor_if;
  logic        sample_valid;
  logic [2:0]  sample_chan;
  logic [15:0] sample_data;
  logic        lim_we;
  logic [3:0]  lim_addr;
  logic [15:0] lim_wdata;
  logic        avg_valid;
  logic [2:0]  avg_chan;
  logic [15:0] avg_data;

  modport master (
    output sample_valid, sample_chan, sample_data, lim_we, lim_addr, lim_wdata,
    input  avg_valid, avg_chan, avg_data
  );

  modport slave (
    input  sample_valid, sample_chan, sample_data, lim_we, lim_addr, lim_wdata,
    output avg_valid, avg_chan, avg_data
  );
endinterface

// File: rtl/adc_channel_monitor.sv
// Eight-channel ADC block averager with per-channel lo/hi window check, persistence
// filtering and sticky fault flags.
module adc_channel_monitor #(
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned PERSIST  = 3
) (
  input  logic                        clk48mhz,
  input  logic                        rstn,
  adc_channel_monitor_if.slave        bus,
  input  logic [7:0]                  fault_clr,
  input  logic [2:0]                  rd_chan,
  output logic [15:0]                 rd_avg,
  output logic [7:0]                  fault,
  output logic                        fault_any
);

  localparam int unsigned AccW       = 16 + AVG_LOG2;
  localparam logic [3:0]  PersistMax = 4'(PERSIST);

  logic [AccW-1:0]     acc_q [8];
  logic [AVG_LOG2-1:0] cnt_q [8];
  logic [15:0]         avg_q [8];
  logic [15:0]         lo_q  [8];
  logic [15:0]         hi_q  [8];
  logic [3:0]          pc_q  [8];
  logic [3:0]          pc_d  [8];
  logic [7:0]          fault_q, fault_d, fault_set;
  logic                fault_any_q;
  logic                avg_valid_q;
  logic [2:0]          avg_chan_q;
  logic [15:0]         avg_data_q;
  logic [15:0]         rd_avg_q;

  logic [2:0]          ch;
  logic [AccW-1:0]     sum;
  logic                last;
  logic [15:0]         new_avg;
  logic                out_win;
  logic [3:0]          pc_inc;

  assign ch = bus.sample_chan;

  // Datapath for the channel addressed by the current sample; compare uses registered limits
  always_comb begin
    sum     = acc_q[ch] + AccW'(bus.sample_data);
    last    = bus.sample_valid && (cnt_q[ch] == '1);
    new_avg = sum[AVG_LOG2 +: 16];
    out_win = (new_avg > hi_q[ch]) || (new_avg < lo_q[ch]);
    pc_inc  = (pc_q[ch] == PersistMax) ? PersistMax : pc_q[ch] + 4'd1;
  end

  // A fault being set overrides a simultaneous clear, both for the flag and its counter
  always_comb begin
    fault_set = '0;
    for (int c = 0; c < 8; c++) begin
      pc_d[c] = pc_q[c];
      if (last && (ch == 3'(c))) begin
        if (out_win) begin
          pc_d[c]      = pc_inc;
          fault_set[c] = (pc_inc == PersistMax);
        end else begin
          pc_d[c] = '0;
        end
      end
      if (fault_clr[c] && !fault_set[c]) begin
        pc_d[c] = '0;
      end
    end
    fault_d = fault_set | (fault_q & ~fault_clr);
  end

  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      for (int c = 0; c < 8; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        avg_q[c] <= '0;
        lo_q[c]  <= 16'h0000;
        hi_q[c]  <= 16'hFFFF;
        pc_q[c]  <= '0;
      end
      fault_q     <= '0;
      fault_any_q <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_chan_q  <= '0;
      avg_data_q  <= '0;
      rd_avg_q    <= '0;
    end else begin
      avg_valid_q <= 1'b0;
      if (bus.sample_valid) begin
        cnt_q[ch] <= cnt_q[ch] + AVG_LOG2'(1);
        if (last) begin
          acc_q[ch]   <= '0;
          avg_q[ch]   <= new_avg;
          avg_valid_q <= 1'b1;
          avg_chan_q  <= ch;
          avg_data_q  <= new_avg;
        end else begin
          acc_q[ch] <= sum;
        end
      end
      if (bus.lim_we) begin
        if (bus.lim_addr[3]) begin
          hi_q[bus.lim_addr[2:0]] <= bus.lim_wdata;
        end else begin
          lo_q[bus.lim_addr[2:0]] <= bus.lim_wdata;
        end
      end
      for (int c = 0; c < 8; c++) begin
        pc_q[c] <= pc_d[c];
      end
      fault_q     <= fault_d;
      fault_any_q <= |fault_q;
      rd_avg_q    <= avg_q[rd_chan];
    end
  end

  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_chan  = avg_chan_q;
  assign bus.avg_data  = avg_data_q;
  assign fault         = fault_q;
  assign fault_any     = fault_any_q;
  assign rd_avg        = rd_avg_q;

endmodule

// File: tb/tb_adc_channel_monitor.sv
// Randomized and directed bench for adc_channel_monitor, checked every cycle against a
// transaction-level reference model built from integer sums and counts.
module tb_adc_channel_monitor;

  localparam int AL = 4;
  localparam int PS = 3;
  localparam int N  = 1 << AL;

  logic        clk48mhz = 1'b0;
  logic        rstn;
  logic [7:0]  fault_clr;
  logic [2:0]  rd_chan;
  logic [15:0] rd_avg;
  logic [7:0]  fault;
  logic        fault_any;

  adc_channel_monitor_if bus ();

  adc_channel_monitor #(
    .AVG_LOG2 (AL),
    .PERSIST  (PS)
  ) dut (
    .clk48mhz  (clk48mhz),
    .rstn      (rstn),
    .bus       (bus),
    .fault_clr (fault_clr),
    .rd_chan   (rd_chan),
    .rd_avg    (rd_avg),
    .fault     (fault),
    .fault_any (fault_any)
  );

  always #10 clk48mhz = ~clk48mhz;

  int n_vec = 0;
  int n_bad = 0;
  int n_pulse = 0;
  logic [15:0] seen_avg [8];

  // Reference model state
  int          msum [8];
  int          mn   [8];
  int          mpc  [8];
  logic [15:0] mavg [8];
  logic [15:0] mlo  [8];
  logic [15:0] mhi  [8];
  logic [7:0]  mfault;
  logic        exp_valid;
  logic [2:0]  exp_chan;
  logic [15:0] exp_data;
  logic        exp_any;
  logic [15:0] exp_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at this edge
  task automatic model_edge();
    logic [7:0] set;
    int         a;
    int         c;
    logic       out;
    if (!rstn) begin
      for (int k = 0; k < 8; k++) begin
        msum[k] = 0;
        mn[k]   = 0;
        mpc[k]  = 0;
        mavg[k] = 16'h0000;
        mlo[k]  = 16'h0000;
        mhi[k]  = 16'hFFFF;
      end
      mfault    = '0;
      exp_valid = 1'b0;
      exp_chan  = '0;
      exp_data  = '0;
      exp_any   = 1'b0;
      exp_rd    = '0;
    end else begin
      exp_any   = |mfault;
      exp_rd    = mavg[rd_chan];
      exp_valid = 1'b0;
      set       = '0;
      if (bus.sample_valid) begin
        c       = int'(bus.sample_chan);
        msum[c] = msum[c] + int'(bus.sample_data);
        mn[c]   = mn[c] + 1;
        if (mn[c] == N) begin
          a   = msum[c] / N;
          out = (a > int'(mhi[c])) || (a < int'(mlo[c]));
          if (out) mpc[c] = (mpc[c] + 1 > PS) ? PS : mpc[c] + 1;
          else     mpc[c] = 0;
          if (out && mpc[c] == PS) set[c] = 1'b1;
          mavg[c]   = 16'(a);
          exp_valid = 1'b1;
          exp_chan  = bus.sample_chan;
          exp_data  = 16'(a);
          msum[c]   = 0;
          mn[c]     = 0;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (fault_clr[k] && !set[k]) mpc[k] = 0;
      end
      mfault = (mfault & ~fault_clr) | set;
      if (bus.lim_we) begin
        if (bus.lim_addr[3]) mhi[bus.lim_addr[2:0]] = bus.lim_wdata;
        else                 mlo[bus.lim_addr[2:0]] = bus.lim_wdata;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk48mhz);
    model_edge();
    #1;
    check_eq("avg_valid", 32'(bus.avg_valid), 32'(exp_valid));
    check_eq("avg_chan",  32'(bus.avg_chan),  32'(exp_chan));
    check_eq("avg_data",  32'(bus.avg_data),  32'(exp_data));
    check_eq("fault",     32'(fault),         32'(mfault));
    check_eq("fault_any", 32'(fault_any),     32'(exp_any));
    check_eq("rd_avg",    32'(rd_avg),        32'(exp_rd));
    if (bus.avg_valid === 1'b1) begin
      n_pulse++;
      seen_avg[bus.avg_chan] = bus.avg_data;
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [15:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_chan  = c;
    bus.sample_data  = d;
    cyc();
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_avg(input logic [2:0] c, input logic [15:0] d);
    repeat (N) send(c, d);
  endtask

  task automatic write_lim(input logic [3:0] addr, input logic [15:0] val);
    bus.lim_we    = 1'b1;
    bus.lim_addr  = addr;
    bus.lim_wdata = val;
    cyc();
    bus.lim_we = 1'b0;
  endtask

  logic [15:0] base [8];
  logic [15:0] rdata;

  initial begin
    for (int k = 0; k < 8; k++) seen_avg[k] = '0;
    rstn             = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_chan  = '0;
    bus.sample_data  = '0;
    bus.lim_we       = 1'b0;
    bus.lim_addr     = '0;
    bus.lim_wdata    = '0;
    fault_clr        = '0;
    rd_chan          = '0;
    repeat (2) cyc();
    check_eq("reset_fault", 32'(fault), 32'h0);
    check_eq("reset_rd_avg", 32'(rd_avg), 32'h0);
    rstn = 1'b1;
    cyc();

    // Single-channel constant block
    n_pulse = 0;
    send_avg(3'd0, 16'h1000);
    check_eq("c0_valid_latency", 32'(bus.avg_valid), 32'h1);
    check_eq("c0_avg", 32'(bus.avg_data), 32'h1000);
    repeat (3) cyc();
    check_eq("c0_pulses", 32'(n_pulse), 32'h1);

    // Interleaved ramp and full-scale channels
    for (int i = 0; i < N; i++) begin
      send(3'd5, 16'(i));
      send(3'd6, 16'hFFFF);
    end
    cyc();
    check_eq("c5_ramp_avg", 32'(seen_avg[5]), 32'h0007);
    check_eq("c6_const_avg", 32'(seen_avg[6]), 32'hFFFF);
    rd_chan = 3'd5;
    cyc();
    check_eq("rd_c5", 32'(rd_avg), 32'h0007);

    // Persistence: two high, one in-window -> no fault; then three high -> fault
    write_lim(4'hA, 16'h9000);
    send_avg(3'd2, 16'hA000);
    send_avg(3'd2, 16'hA000);
    send_avg(3'd2, 16'h8000);
    check_eq("c2_no_fault", 32'(fault[2]), 32'h0);
    send_avg(3'd2, 16'hA000);
    send_avg(3'd2, 16'hA000);
    check_eq("c2_two_high", 32'(fault[2]), 32'h0);
    send_avg(3'd2, 16'hA000);
    check_eq("c2_fault_with_valid", 32'({bus.avg_valid, fault[2]}), 32'h3);
    check_eq("c2_any_lag", 32'(fault_any), 32'h0);
    cyc();
    check_eq("c2_any_set", 32'(fault_any), 32'h1);

    // Clear alone, counter restart, then set wins over simultaneous clear
    fault_clr = 8'h04;
    cyc();
    fault_clr = 8'h00;
    check_eq("c2_cleared", 32'(fault[2]), 32'h0);
    send_avg(3'd2, 16'hA000);
    send_avg(3'd2, 16'hA000);
    check_eq("c2_pc_restarted", 32'(fault[2]), 32'h0);
    repeat (N - 1) send(3'd2, 16'hA000);
    fault_clr = 8'h04;
    send(3'd2, 16'hA000);
    fault_clr = 8'h00;
    check_eq("c2_set_wins", 32'(fault[2]), 32'h1);
    fault_clr = 8'h04;
    cyc();
    fault_clr = 8'h00;
    check_eq("c2_clear_later", 32'(fault[2]), 32'h0);
    send_avg(3'd2, 16'hA000);
    check_eq("c2_one_after_clr", 32'(fault[2]), 32'h0);

    // Reset mid-accumulation with strobes asserted during reset
    for (int i = 0; i < N / 2; i++) send(3'd1, 16'($urandom));
    rstn             = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_chan  = 3'd1;
    bus.sample_data  = 16'hFFFF;
    bus.lim_we       = 1'b1;
    bus.lim_addr     = 4'h9;
    bus.lim_wdata    = 16'h0000;
    fault_clr        = 8'hFF;
    cyc();
    rstn             = 1'b1;
    bus.sample_valid = 1'b0;
    bus.lim_we       = 1'b0;
    fault_clr        = 8'h00;
    n_pulse          = 0;
    send_avg(3'd1, 16'h2000);
    cyc();
    check_eq("c1_pulses", 32'(n_pulse), 32'h1);
    check_eq("c1_avg", 32'(seen_avg[1]), 32'h2000);
    repeat (3) send_avg(3'd2, 16'hA000);
    check_eq("hi_lim_reset", 32'(fault[2]), 32'h0);
    repeat (3) send_avg(3'd1, 16'h0000);
    check_eq("lo_lim_reset", 32'(fault[1]), 32'h0);

    // Limit written in the same cycle as the compare is not yet in force
    repeat (N - 1) send(3'd3, 16'h3000);
    bus.lim_we    = 1'b1;
    bus.lim_addr  = 4'h3;
    bus.lim_wdata = 16'h4000;
    send(3'd3, 16'h3000);
    bus.lim_we = 1'b0;
    check_eq("c3_old_lim", 32'(fault[3]), 32'h0);
    send_avg(3'd3, 16'h3000);
    send_avg(3'd3, 16'h3000);
    check_eq("c3_two_out", 32'(fault[3]), 32'h0);
    send_avg(3'd3, 16'h3000);
    check_eq("c3_three_out", 32'(fault[3]), 32'h1);

    // Random traffic
    for (int k = 0; k < 8; k++) base[k] = 16'($urandom_range(16'hEFFF));
    for (int i = 0; i < 6000; i++) begin
      bus.sample_valid = ($urandom_range(9) < 8);
      bus.sample_chan  = 3'($urandom);
      rdata            = base[bus.sample_chan] + 16'($urandom_range(4095));
      bus.sample_data  = rdata;
      bus.lim_we       = ($urandom_range(49) == 0);
      bus.lim_addr     = 4'($urandom);
      bus.lim_wdata    = 16'($urandom);
      fault_clr        = ($urandom_range(29) == 0) ? 8'($urandom) : 8'h00;
      rd_chan          = 3'($urandom);
      rstn             = ($urandom_range(1999) != 0);
      cyc();
    end
    rstn             = 1'b1;
    bus.sample_valid = 1'b0;
    bus.lim_we       = 1'b0;
    fault_clr        = 8'h00;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_channel_monitor.md
ADC_CHANNEL_MONITOR -- requirements
Module: adc_channel_monitor

Interface
REQ-001 SHALL provide parameter AVG_LOG2, default 4: log2 of the number of samples averaged per channel (range 1..8).
REQ-002 SHALL provide parameter PERSIST, default 3: number of consecutive out-of-window averages needed to flag a fault (range 1..15).
REQ-003 SHALL have port clk48mhz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; sample_chan and sample_data are valid this cycle.
REQ-006 SHALL have port sample_chan  input  3  ADC channel (0..7) of the sample.
REQ-007 SHALL have port sample_data  input  16  raw ADS8688 code, offset binary, unsigned.
REQ-008 SHALL have port lim_we  input  1  limit write strobe.
REQ-009 SHALL have port lim_addr  input  4  limit select: bit3=1 selects hi limit, bit3=0 selects lo limit; bits[2:0] select the channel.
REQ-010 SHALL have port lim_wdata  input  16  limit value.
REQ-011 SHALL have port fault_clr  input  8  per-channel fault clear, one bit per channel.
REQ-012 SHALL have port rd_chan  input  3  average readback channel select.
REQ-013 SHALL have port rd_avg  output  16  last average of rd_chan, registered.
REQ-014 SHALL have port avg_valid  output  1  one-cycle strobe marking a new average.
REQ-015 SHALL have port avg_chan  output  3  channel of the new average.
REQ-016 SHALL have port avg_data  output  16  value of the new average.
REQ-017 SHALL have port fault  output  8  sticky per-channel limit faults.
REQ-018 SHALL have port fault_any  output  1  OR of fault[7:0], registered.

Function
REQ-019 SHALL keep, per channel, an accumulator of (16+AVG_LOG2) bits and a sample counter of AVG_LOG2 bits.
REQ-020 SHALL, on each sample_valid, add sample_data to acc[sample_chan] and increment cnt[sample_chan]; no overflow is possible.
REQ-021 SHALL, when a sample arrives with cnt[c] at its maximum value (2^AVG_LOG2 - 1), do all of the following:
  - register avg[c] = (acc[c] + sample_data) >> AVG_LOG2, truncating;
  - clear acc[c] and wrap cnt[c] to 0;
  - on the next cycle, pulse avg_valid with avg_chan = c and avg_data equal to that average (latency 1 clock).
REQ-022 SHALL accept sample_valid on every cycle, including back-to-back samples on the same channel and interleaved channels, with no backpressure and no lost samples.
REQ-023 SHALL hold avg_chan and avg_data stable between avg_valid pulses.
REQ-024 SHALL, on lim_we, write lim_wdata into lo_lim[lim_addr[2:0]] when lim_addr[3]=0, or into hi_lim[lim_addr[2:0]] when lim_addr[3]=1.
REQ-025 SHALL, on each new average of channel c, evaluate it as out-of-window when avg > hi_lim[c] or avg < lo_lim[c] (unsigned compare).
  - A limit written in the same cycle as the compare is not used; the compare uses the previous value.
REQ-026 SHALL keep a per-channel persistence counter pc[c], updated on each new average of channel c:
  - out-of-window: pc[c] increments, saturating at PERSIST;
  - in-window: pc[c] returns to 0.
REQ-027 SHALL set fault[c] in the cycle pc[c] reaches PERSIST, i.e. the same cycle avg_valid is asserted for that average.
REQ-028 SHALL keep fault[c] set until fault_clr[c]=1; clearing fault[c] also resets pc[c] to 0.
  - If set and clear occur in the same cycle, set wins.
REQ-029 SHALL update fault_any one cycle after fault changes.
REQ-030 SHALL update rd_avg one cycle after rd_chan with avg[rd_chan]; a same-cycle avg update is visible one cycle later.

Reset
REQ-031 SHALL, while rstn=0 at a clock edge, reset the following:
  - accumulators, counters, pc and avg to 0;
  - lo_lim to 0x0000 and hi_lim to 0xFFFF, so no fault is possible by default;
  - fault, fault_any, avg_valid, avg_chan, avg_data and rd_avg to 0.
REQ-032 SHALL, on reset asserted mid-accumulation, discard the partial sums; the first average after release uses exactly 2^AVG_LOG2 new samples.
REQ-033 SHALL ignore sample_valid, lim_we and fault_clr while rstn=0.

Verification
REQ-034 SHALL cover, with AVG_LOG2=4: 16 samples of 0x1000 on channel 0 -> exactly one avg_valid, one clock after the 16th sample, with avg_chan=0 and avg_data=0x1000.
REQ-035 SHALL cover: ramp 0..15 on channel 5 interleaved with constant 0xFFFF on channel 6 -> channel 5 average 0x0007, channel 6 average 0xFFFF, with channel 6 not affected by channel 5.
REQ-036 SHALL cover, with hi_lim[2]=0x9000 and PERSIST=3:
  - three consecutive channel 2 averages of 0xA000 -> fault[2]=1 with the third avg_valid, fault_any=1 one clock later;
  - two averages of 0xA000 followed by one of 0x8000 -> no fault.
REQ-037 SHALL cover: fault_clr[2] pulsed in the same cycle fault[2] is set -> fault[2] stays 1; fault_clr[2] pulsed alone later -> fault[2]=0 and pc[2]=0.
REQ-038 SHALL cover: rstn=0 after 8 of 16 samples on channel 1, then 16 samples of 0x2000 -> a single average of 0x2000 and limits back at 0x0000/0xFFFF.
REQ-039 SHALL cover: lim_we writing lo_lim[3]=0x4000 in the same cycle as a channel 3 average of 0x3000 -> that average is compared against the old limit 0x0000 (in-window), and the next average of 0x3000 is out-of-window.
